// File: rtl/fight_round_ctrl.sv
// fight_round_ctrl: match referee for the two-player fighting datapath.
// Collects one action per player, commits both with a single step pulse,
// runs the round timer, tallies round wins and declares the match winner.
// Optional build macro FIGHT_IDLE_TIMEOUT_EN: a player that stays silent for
// IDLE_LIMIT collect cycles is committed as "await" so the exchange proceeds.
module fight_round_ctrl #(
    parameter int ROUND_TICKS   = 60,
    parameter int TIMER_W       = 6,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int IDLE_LIMIT    = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         act1_in,
    input  logic               act1_vld,
    input  logic [2:0]         act2_in,
    input  logic               act2_vld,
    input  logic [1:0]         health1,
    input  logic [1:0]         health2,
    output logic               step,
    output logic [2:0]         action1,
    output logic [2:0]         action2,
    output logic               player_rst,
    output logic [TIMER_W-1:0] timer,
    output logic [1:0]         wins1,
    output logic [1:0]         wins2,
    output logic               round_over,
    output logic               match_over,
    output logic [1:0]         winner
);
    localparam logic [2:0] ACT_AWAIT = 3'b010;
    localparam int         RC_W      = $clog2(MAX_ROUNDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET_P, S_COLLECT, S_STEP, S_CHECK, S_ROUND_END, S_MATCH_END
    } state_t;

    state_t             state_q, state_d;
    logic               flag1_q, flag1_d, flag2_q, flag2_d;
    logic [2:0]         lat1_q, lat1_d, lat2_q, lat2_d;
    logic               step_q, step_d, player_rst_q, player_rst_d;
    logic               round_over_q, round_over_d, match_over_q, match_over_d;
    logic [2:0]         action1_q, action1_d, action2_q, action2_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         wins1_q, wins1_d, wins2_q, wins2_d, winner_q, winner_d;
    logic [RC_W-1:0]    round_cnt_q, round_cnt_d;

    // Combinational helpers for the collect phase and round scoring
    logic               flag1_new, flag2_new, commit_now, enter_reset;
    logic [2:0]         lat1_new, lat2_new;
    logic               p1_takes, p2_takes;

`ifdef FIGHT_IDLE_TIMEOUT_EN
    localparam int CNT_W = $clog2(IDLE_LIMIT + 1);
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    // Next-state and next-output computation for the referee FSM
    always_comb begin
        state_d      = state_q;
        flag1_d      = flag1_q;
        flag2_d      = flag2_q;
        lat1_d       = lat1_q;
        lat2_d       = lat2_q;
        step_d       = 1'b0;
        player_rst_d = 1'b0;
        round_over_d = 1'b0;
        match_over_d = match_over_q;
        action1_d    = action1_q;
        action2_d    = action2_q;
        timer_d      = timer_q;
        wins1_d      = wins1_q;
        wins2_d      = wins2_q;
        winner_d     = winner_q;
        round_cnt_d  = round_cnt_q;
        enter_reset  = 1'b0;
        p1_takes     = 1'b0;
        p2_takes     = 1'b0;
        // First valid action per player wins; later valids are ignored
        flag1_new    = flag1_q | act1_vld;
        flag2_new    = flag2_q | act2_vld;
        lat1_new     = (act1_vld && !flag1_q) ? act1_in : lat1_q;
        lat2_new     = (act2_vld && !flag2_q) ? act2_in : lat2_q;
        commit_now   = flag1_new && flag2_new;
`ifdef FIGHT_IDLE_TIMEOUT_EN
        idle_cnt_d   = idle_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RESET_P;
                    enter_reset = 1'b1;
                end
            end
            S_RESET_P: begin
                state_d = S_COLLECT;
`ifdef FIGHT_IDLE_TIMEOUT_EN
                idle_cnt_d = '0;
`endif
            end
            S_COLLECT: begin
`ifdef FIGHT_IDLE_TIMEOUT_EN
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
                if (!commit_now && idle_cnt_q == CNT_W'(IDLE_LIMIT)) begin
                    // Silent player is committed as await
                    if (!flag1_new) lat1_new = ACT_AWAIT;
                    if (!flag2_new) lat2_new = ACT_AWAIT;
                    flag1_new  = 1'b1;
                    flag2_new  = 1'b1;
                    commit_now = 1'b1;
                end
`endif
                flag1_d = flag1_new;
                flag2_d = flag2_new;
                lat1_d  = lat1_new;
                lat2_d  = lat2_new;
                if (commit_now) begin
                    state_d   = S_STEP;
                    step_d    = 1'b1;
                    action1_d = lat1_new;
                    action2_d = lat2_new;
                    timer_d   = (timer_q == '0) ? '0 : timer_q - TIMER_W'(1);
                end
            end
            S_STEP: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Health inputs have absorbed the step by now
                if (health1 == 2'd0 || health2 == 2'd0 || timer_q == '0) begin
                    state_d      = S_ROUND_END;
                    round_over_d = 1'b1;
                    round_cnt_d  = round_cnt_q + RC_W'(1);
                    if (health1 == 2'd0 && health2 == 2'd0) begin
                        p1_takes = 1'b0;
                    end else if (health1 == 2'd0) begin
                        p2_takes = 1'b1;
                    end else if (health2 == 2'd0) begin
                        p1_takes = 1'b1;
                    end else begin
                        p1_takes = health1 > health2;
                        p2_takes = health2 > health1;
                    end
                    if (p1_takes && wins1_q != 2'b11) wins1_d = wins1_q + 2'd1;
                    if (p2_takes && wins2_q != 2'b11) wins2_d = wins2_q + 2'd1;
                end else begin
                    state_d = S_COLLECT;
                    flag1_d = 1'b0;
                    flag2_d = 1'b0;
`ifdef FIGHT_IDLE_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            S_ROUND_END: begin
                if (wins1_q == 2'(ROUNDS_TO_WIN) || wins2_q == 2'(ROUNDS_TO_WIN) ||
                    round_cnt_q == RC_W'(MAX_ROUNDS)) begin
                    state_d      = S_MATCH_END;
                    match_over_d = 1'b1;
                    winner_d     = (wins1_q > wins2_q) ? 2'b01 :
                                   (wins2_q > wins1_q) ? 2'b10 : 2'b11;
                end else begin
                    state_d     = S_RESET_P;
                    enter_reset = 1'b1;
                end
            end
            S_MATCH_END: begin
                if (start) begin
                    state_d      = S_RESET_P;
                    enter_reset  = 1'b1;
                    match_over_d = 1'b0;
                    winner_d     = 2'b00;
                    wins1_d      = 2'd0;
                    wins2_d      = 2'd0;
                    round_cnt_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Common entry actions for a fresh round
        if (enter_reset) begin
            player_rst_d = 1'b1;
            timer_d      = TIMER_W'(ROUND_TICKS);
            flag1_d      = 1'b0;
            flag2_d      = 1'b0;
        end
    end

    // State and registered outputs; reset drops any uncommitted action
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            flag1_q      <= 1'b0;
            flag2_q      <= 1'b0;
            lat1_q       <= ACT_AWAIT;
            lat2_q       <= ACT_AWAIT;
            step_q       <= 1'b0;
            player_rst_q <= 1'b0;
            round_over_q <= 1'b0;
            match_over_q <= 1'b0;
            action1_q    <= ACT_AWAIT;
            action2_q    <= ACT_AWAIT;
            timer_q      <= '0;
            wins1_q      <= 2'd0;
            wins2_q      <= 2'd0;
            winner_q     <= 2'b00;
            round_cnt_q  <= '0;
`ifdef FIGHT_IDLE_TIMEOUT_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            flag1_q      <= flag1_d;
            flag2_q      <= flag2_d;
            lat1_q       <= lat1_d;
            lat2_q       <= lat2_d;
            step_q       <= step_d;
            player_rst_q <= player_rst_d;
            round_over_q <= round_over_d;
            match_over_q <= match_over_d;
            action1_q    <= action1_d;
            action2_q    <= action2_d;
            timer_q      <= timer_d;
            wins1_q      <= wins1_d;
            wins2_q      <= wins2_d;
            winner_q     <= winner_d;
            round_cnt_q  <= round_cnt_d;
`ifdef FIGHT_IDLE_TIMEOUT_EN
            idle_cnt_q   <= idle_cnt_d;
`endif
        end
    end

    assign step       = step_q;
    assign action1    = action1_q;
    assign action2    = action2_q;
    assign player_rst = player_rst_q;
    assign timer      = timer_q;
    assign wins1      = wins1_q;
    assign wins2      = wins2_q;
    assign round_over = round_over_q;
    assign match_over = match_over_q;
    assign winner     = winner_q;
endmodule

// File: tb/tb_fight_round_ctrl.sv
// tb_fight_round_ctrl: directed match scenarios followed by random stimulus,
// checked every cycle against a protocol-level model of a match.
module tb_fight_round_ctrl;
    localparam int         RT    = 60;
    localparam int         RTW   = 2;
    localparam int         MAXR  = 5;
    localparam int         ILIM  = 15;
    localparam logic [2:0] AWAIT = 3'b010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] act1_in = 3'd0, act2_in = 3'd0;
    logic       act1_vld = 1'b0, act2_vld = 1'b0;
    logic [1:0] health1 = 2'd3, health2 = 2'd3;
    logic       step, player_rst, round_over, match_over;
    logic [2:0] action1, action2;
    logic [5:0] timer;
    logic [1:0] wins1, wins2, winner;

    fight_round_ctrl #(
        .ROUND_TICKS(RT), .TIMER_W(6), .ROUNDS_TO_WIN(RTW),
        .MAX_ROUNDS(MAXR), .IDLE_LIMIT(ILIM)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .act1_in(act1_in), .act1_vld(act1_vld),
        .act2_in(act2_in), .act2_vld(act2_vld),
        .health1(health1), .health2(health2),
        .step(step), .action1(action1), .action2(action2),
        .player_rst(player_rst), .timer(timer),
        .wins1(wins1), .wins2(wins2),
        .round_over(round_over), .match_over(match_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int printed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
            end
        end
    endtask

    // ---------------- protocol-level reference model ----------------
    bit         model_ready = 1'b0;
    logic       s_start, s_rst, s_v1, s_v2;
    logic [2:0] s_a1, s_a2;
    logic [1:0] s_h1, s_h2;
    logic       exp_step = 1'b0, exp_prst = 1'b0, exp_rover = 1'b0, exp_mover = 1'b0;
    logic [2:0] exp_a1 = AWAIT, exp_a2 = AWAIT;
    logic [5:0] exp_timer = 6'd0;
    logic [1:0] exp_w1 = 2'd0, exp_w2 = 2'd0, exp_winner = 2'd0;

    // Advance one clock; pulses fall, reset restores the idle picture
    task automatic tick(output bit ab);
        @(posedge clk);
        s_start = start; s_rst = rst;
        s_v1 = act1_vld; s_a1 = act1_in; s_v2 = act2_vld; s_a2 = act2_in;
        s_h1 = health1; s_h2 = health2;
        ab = s_rst;
        exp_step = 1'b0; exp_prst = 1'b0; exp_rover = 1'b0;
        if (ab) begin
            exp_a1 = AWAIT; exp_a2 = AWAIT; exp_timer = 6'd0;
            exp_w1 = 2'd0; exp_w2 = 2'd0; exp_winner = 2'd0; exp_mover = 1'b0;
            model_ready = 1'b1;
        end
    endtask

    // One whole match, from the edge that accepted start; returns only on reset
    task automatic play_match(output bit ab);
        int rounds;
        int waited;
        bit got1, got2, round_done;
        logic [2:0] l1, l2;
        rounds = 0; l1 = AWAIT; l2 = AWAIT;
        forever begin
            exp_prst = 1'b1;
            exp_timer = 6'(RT);
            tick(ab); if (ab) return;
            round_done = 1'b0;
            while (!round_done) begin
                got1 = 1'b0; got2 = 1'b0; waited = 0;
                while (!(got1 && got2)) begin
                    tick(ab); if (ab) return;
                    if (s_v1 && !got1) begin got1 = 1'b1; l1 = s_a1; end
                    if (s_v2 && !got2) begin got2 = 1'b1; l2 = s_a2; end
`ifdef FIGHT_IDLE_TIMEOUT_EN
                    if (!(got1 && got2) && waited == ILIM) begin
                        if (!got1) l1 = AWAIT;
                        if (!got2) l2 = AWAIT;
                        got1 = 1'b1; got2 = 1'b1;
                    end
`endif
                    waited++;
                end
                exp_step = 1'b1; exp_a1 = l1; exp_a2 = l2;
                if (exp_timer != 6'd0) exp_timer = exp_timer - 6'd1;
                tick(ab); if (ab) return;
                tick(ab); if (ab) return;
                if (s_h1 == 2'd0 || s_h2 == 2'd0 || exp_timer == 6'd0) round_done = 1'b1;
            end
            exp_rover = 1'b1;
            rounds++;
            if (s_h1 != 2'd0 && (s_h2 == 2'd0 || s_h1 > s_h2)) begin
                if (exp_w1 != 2'd3) exp_w1 = exp_w1 + 2'd1;
            end else if (s_h2 != 2'd0 && (s_h1 == 2'd0 || s_h2 > s_h1)) begin
                if (exp_w2 != 2'd3) exp_w2 = exp_w2 + 2'd1;
            end
            tick(ab); if (ab) return;
            if (int'(exp_w1) == RTW || int'(exp_w2) == RTW || rounds == MAXR) begin
                exp_mover = 1'b1;
                exp_winner = (exp_w1 > exp_w2) ? 2'b01 : (exp_w2 > exp_w1) ? 2'b10 : 2'b11;
                do begin
                    tick(ab); if (ab) return;
                end while (!s_start);
                exp_w1 = 2'd0; exp_w2 = 2'd0; exp_winner = 2'd0; exp_mover = 1'b0;
                rounds = 0;
            end
        end
    endtask

    initial begin : model
        bit ab;
        forever begin
            tick(ab);
            if (!ab && s_start) play_match(ab);
        end
    end

    // ---------------- directed helpers ----------------
    function automatic logic pick(input int which);
        case (which)
            0: pick = step;
            1: pick = player_rst;
            2: pick = round_over;
            default: pick = match_over;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = pick(which);
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic exchange(input logic [2:0] a1, input logic [2:0] a2,
                            input logic [1:0] h1, input logic [1:0] h2);
        act1_in = a1; act2_in = a2; act1_vld = 1'b1; act2_vld = 1'b1;
        wait_for(0, 40, "exchange_step");
        act1_vld = 1'b0; act2_vld = 1'b0;
        health1 = h1; health2 = h2;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // ---------------- stimulus and every-cycle compare ----------------
    initial begin : stim
        int nsteps;
        fork
            forever begin
                @(negedge clk);
                if (model_ready) begin
                    check("step", 32'(step), 32'(exp_step));
                    check("player_rst", 32'(player_rst), 32'(exp_prst));
                    check("round_over", 32'(round_over), 32'(exp_rover));
                    check("match_over", 32'(match_over), 32'(exp_mover));
                    check("action1", 32'(action1), 32'(exp_a1));
                    check("action2", 32'(action2), 32'(exp_a2));
                    check("timer", 32'(timer), 32'(exp_timer));
                    check("wins1", 32'(wins1), 32'(exp_w1));
                    check("wins2", 32'(wins2), 32'(exp_w2));
                    check("winner", 32'(winner), 32'(exp_winner));
                    if (round_over === 1'b1)
                        $display("round over t=%0t wins1=%0d wins2=%0d", $time, wins1, wins2);
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_step", 32'(step), 32'd0);
        check("rst_action1", 32'(action1), 32'(AWAIT));
        check("rst_timer", 32'(timer), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_match_over", 32'(match_over), 32'd0);

        // First exchange: both valid together, step one cycle later
        start = 1'b1;
        wait_for(1, 10, "first_prst");
        start = 1'b0;
        check("round_timer_load", 32'(timer), 32'd60);
        @(negedge clk);
        act1_in = 3'b000; act2_in = 3'b001; act1_vld = 1'b1; act2_vld = 1'b1;
        @(negedge clk);
        act1_vld = 1'b0; act2_vld = 1'b0;
        check("first_step", 32'(step), 32'd1);
        check("first_action1", 32'(action1), 32'b000);
        check("first_action2", 32'(action2), 32'b001);
        check("first_timer", 32'(timer), 32'd59);

        // P2 knocked out
        health2 = 2'd0;
        wait_for(2, 10, "ko_round_over");
        check("ko_wins1", 32'(wins1), 32'd1);
        health2 = 2'd3;
        wait_for(1, 10, "ko_prst");
        check("ko_timer_reload", 32'(timer), 32'd60);

        // Second P1 win ends the match
        exchange(3'b010, 3'b010, 2'd3, 2'd0);
        check("m1_round_over", 32'(round_over), 32'd1);
        health2 = 2'd3;
        @(negedge clk);
        check("m1_match_over", 32'(match_over), 32'd1);
        check("m1_winner", 32'(winner), 32'b01);
        act1_vld = 1'b1; act2_vld = 1'b1; nsteps = 0;
        repeat (10) begin
            @(negedge clk);
            if (step === 1'b1) nsteps++;
        end
        act1_vld = 1'b0; act2_vld = 1'b0;
        check("m1_no_step_after_end", 32'(nsteps), 32'd0);
        pulse_start();
        check("restart_wins1", 32'(wins1), 32'd0);
        check("restart_prst", 32'(player_rst), 32'd1);

        // Reset with only act1 latched
        act1_in = 3'b111; act1_vld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        act1_vld = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_step", 32'(step), 32'd0);
        check("midrst_action1", 32'(action1), 32'(AWAIT));
        check("midrst_timer", 32'(timer), 32'd0);

        // Five double-KO rounds
        pulse_start();
        repeat (5) begin
            exchange(3'b000, 3'b000, 2'd0, 2'd0);
            health1 = 2'd3; health2 = 2'd3;
        end
        @(negedge clk);
        check("draw_match_over", 32'(match_over), 32'd1);
        check("draw_winner", 32'(winner), 32'b11);
        check("draw_wins1", 32'(wins1), 32'd0);

        // Timeout round decided on health
        pulse_start();
        repeat (RT) exchange(3'b100, 3'b101, 2'd3, 2'd1);
        check("timeout_round_over", 32'(round_over), 32'd1);
        check("timeout_wins1", 32'(wins1), 32'd1);
        health1 = 2'd3; health2 = 2'd3;

`ifdef FIGHT_IDLE_TIMEOUT_EN
        // Silent player 2 is committed as await
        act1_in = 3'b110; act1_vld = 1'b1;
        wait_for(0, ILIM + 12, "idle_step");
        act1_vld = 1'b0;
        check("idle_action1", 32'(action1), 32'b110);
        check("idle_action2", 32'(action2), 32'(AWAIT));
`endif

        // Random traffic
        repeat (6000) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 499) == 0);
            start    = ($urandom_range(0, 7) == 0);
            act1_vld = ($urandom_range(0, 2) == 0);
            act2_vld = ($urandom_range(0, 2) == 0);
            act1_in  = 3'($urandom_range(0, 7));
            act2_in  = 3'($urandom_range(0, 7));
            health1  = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            health2  = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        end
        rst = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
